// File: rtl/mips_decls_p.sv
`default_nettype none
// ============================================================================
// mips_decls_p : shared MIPS execute-stage encodings (funct, ALU, mul/div)
// Revision 1.0
// ============================================================================
package mips_decls_p;

  typedef enum logic [5:0] {
    F_MFHI  = 6'h10,
    F_MFLO  = 6'h12,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1A,
    F_DIVU  = 6'h1B,
    F_ADD   = 6'h20,
    F_SUB   = 6'h22,
    F_AND   = 6'h24,
    F_OR    = 6'h25,
    F_SLT   = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b010,
    SUB = 3'b110,
    SLT = 3'b111
  } alucontrol_t;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    HI  = 2'd1,
    LO  = 2'd2
  } res_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  function automatic logic is_muldiv(input funct_t f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// muldiv_core : iterative shift-add multiplier / restoring divider with HI/LO
// Revision 1.0
// ============================================================================
module muldiv_core
  import mips_decls_p::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  funct_t           funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_ITERS = FAST_MUL ? CW'(WIDTH / 2) : CW'(WIDTH);
  localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d, is_div_q, is_div_d;

  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
  logic [WIDTH:0]   div_shift, div_trial;

  // acc_lo holds the multiplier bits not yet consumed; product bits shift in from the top
  if (FAST_MUL) begin : g_radix4
    logic [WIDTH+1:0] sum;
    always_comb begin
      sum = {2'b00, acc_hi_q}
          + (acc_lo_q[0] ? {2'b00, m_q} : '0)
          + (acc_lo_q[1] ? {1'b0, m_q, 1'b0} : '0);
      mul_hi_nxt = sum[WIDTH+1:2];
      mul_lo_nxt = {sum[1:0], acc_lo_q[WIDTH-1:2]};
    end
  end else begin : g_radix2
    logic [WIDTH:0] sum;
    always_comb begin
      sum        = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
      mul_hi_nxt = sum[WIDTH:1];
      mul_lo_nxt = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial  = div_shift - {1'b0, m_q};
    div_hi_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_lo_nxt = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  always_comb begin
    logic signed_op, a_neg, b_neg, div_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;

    signed_op = (funct == F_MULT) || (funct == F_DIV);
    div_op    = (funct == F_DIV) || (funct == F_DIVU);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
    prod      = {acc_hi_q, acc_lo_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_hi_d = '0;
          acc_lo_d = div_op ? abs_a : abs_b;
          m_d      = div_op ? abs_b : abs_a;
          a_d      = a;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          div0_d   = div_op && (b == '0);
          is_div_d = div_op;
          cnt_d    = div_op ? DIV_ITERS : MUL_ITERS;
          state_d  = div_op ? DIV : MUL;
        end
      end
      MUL: begin
        acc_hi_d = mul_hi_nxt;
        acc_lo_d = mul_lo_nxt;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      DIV: begin
        acc_hi_d = div_hi_nxt;
        acc_lo_d = div_lo_nxt;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      default: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_lo_q ? -prod : prod;
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
        end
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// alu_muldiv_ctrl : execute-stage ALU decode, result select and mul/div stall
// Revision 1.0
// ============================================================================
module alu_muldiv_ctrl
  import mips_decls_p::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  funct_t           funct,
  input  logic [1:0]       aluop,
  input  logic             issue,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       alucontrol,
  output logic [1:0]       res_sel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic rtype, md_funct, hilo_funct, start;

  always_comb begin
    alucontrol = 3'bxxx;
    res_sel    = ALU;
    case (aluop)
      2'b00: alucontrol = ADD;
      2'b01: alucontrol = SUB;
      2'b10: begin
        case (funct)
          F_ADD:  alucontrol = ADD;
          F_SUB:  alucontrol = SUB;
          F_AND:  alucontrol = AND;
          F_OR:   alucontrol = OR;
          F_SLT:  alucontrol = SLT;
          // ALU result is discarded for these, so give it a harmless op
          F_MULT, F_MULTU, F_DIV, F_DIVU: alucontrol = ADD;
          F_MFHI: begin alucontrol = ADD; res_sel = HI; end
          F_MFLO: begin alucontrol = ADD; res_sel = LO; end
          default: alucontrol = 3'bxxx;
        endcase
      end
      default: alucontrol = 3'bxxx;
    endcase
  end

  assign rtype      = (aluop == 2'b10);
  assign md_funct   = is_muldiv(funct);
  assign hilo_funct = (funct == F_MFHI) || (funct == F_MFLO);
  assign start      = issue && rtype && md_funct && !busy;
  assign stall      = reset_n && issue && busy && rtype && (md_funct || hilo_funct);

  muldiv_core #(
    .WIDTH    (WIDTH),
    .FAST_MUL (FAST_MUL)
  ) u_muldiv_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct   (funct),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
`default_nettype wire
